// File: rtl/pipeline_mem_responder_pkg.sv
// Shared state encoding and constants for the pipeline memory responder.
package mem_resp_types;

   typedef enum logic [1:0] {
      IDLE,
      IFETCH,
      DACCESS,
      COMMIT
   } resp_state_t;

   localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/pipeline_mem_responder_if.sv
// Datapath-side and pmem-side bus of the pipeline memory responder.
// The responder uses the slave modport; the datapath/pmem environment uses master.
interface pipeline_mem_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  iread;
   logic [ADDR_W-1:0]     inst_addr;
   logic                  dread;
   logic                  dwrite;
   logic [ADDR_W-1:0]     mem_address;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_byte_enable;
   logic [DATA_W-1:0]     inst;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  load_pipeline;
   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_W-1:0]     pmem_address;
   logic [DATA_W-1:0]     pmem_wdata;
   logic [DATA_W/8-1:0]   pmem_byte_enable;
   logic [DATA_W-1:0]     pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  iread, inst_addr, dread, dwrite, mem_address, mem_wdata, mem_byte_enable,
      input  pmem_rdata, pmem_resp,
      output inst, mem_rdata, load_pipeline,
      output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
   );

   modport master (
      output iread, inst_addr, dread, dwrite, mem_address, mem_wdata, mem_byte_enable,
      output pmem_rdata, pmem_resp,
      input  inst, mem_rdata, load_pipeline,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
   );
endinterface

// File: rtl/pipeline_mem_responder_watchdog.sv
// resp_watchdog: counts cycles spent waiting on pmem_resp and raises a sticky err
// once WDOG_CYCLES waiting cycles elapse without the state being re-entered.
module resp_watchdog #(
   parameter int WDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_countEn,
   output logic o_err
);
   localparam int CW = $clog2(WDOG_CYCLES + 1);

   logic [CW-1:0] r_count;
   logic          r_err;

   // The counter saturates so a very long stall cannot wrap it back below the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (i_clear) begin
            r_count <= '0;
         end else if (i_countEn && (r_count != CW'(WDOG_CYCLES))) begin
            r_count <= r_count + CW'(1);
         end
         if (i_countEn && !i_clear && (r_count == CW'(WDOG_CYCLES - 1))) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_err = r_err;

endmodule

// File: rtl/pipeline_mem_responder.sv
// pipeline_mem_responder: serves one fetch plus at most one data access per pipeline step
// over a single pmem port, then pulses load_pipeline. Optional macro: INST_REUSE_EN.
module pipeline_mem_responder
   import mem_resp_types::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pipeline_mem_responder_if.slave  bus,
   output logic                     err
);

   resp_state_t           r_state;
   resp_state_t           w_next;
   resp_state_t           w_nr;
   logic                  w_skipFetch;
   logic                  w_wdClear;
   logic                  w_wdCountEn;
   logic                  w_unusedBits;

   logic [DATA_W-1:0]     r_inst;
   logic [DATA_W-1:0]     r_memRdata;
   logic                  r_loadPipeline;
   logic                  r_pmemRead;
   logic                  r_pmemWrite;
   logic [ADDR_W-1:0]     r_pmemAddress;
   logic [DATA_W-1:0]     r_pmemWdata;
   logic [DATA_W/8-1:0]   r_pmemBe;

`ifdef INST_REUSE_EN
   logic [ADDR_W-1:0]     r_lastIaddr;
   logic                  r_tagValid;

   // A store into the cached fetch word must force the next step to refetch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastIaddr <= '0;
         r_tagValid  <= 1'b0;
      end else if ((r_state == IFETCH) && bus.pmem_resp) begin
         r_lastIaddr <= bus.inst_addr;
         r_tagValid  <= 1'b1;
      end else if ((r_state == DACCESS) && bus.pmem_resp && bus.dwrite &&
                   (bus.mem_address[ADDR_W-1:2] == r_lastIaddr[ADDR_W-1:2])) begin
         r_tagValid  <= 1'b0;
      end
   end

   assign w_skipFetch = bus.iread & r_tagValid & (bus.inst_addr == r_lastIaddr);
`else
   assign w_skipFetch = 1'b0;
`endif

   assign w_unusedBits = ^{bus.inst_addr[1:0], bus.mem_address[1:0]};

   // Next-request rule, evaluated on leaving IDLE and COMMIT.
   always_comb begin
      w_nr = COMMIT;
      if (bus.iread && !w_skipFetch) begin
         w_nr = IFETCH;
      end else if (bus.dread || bus.dwrite) begin
         w_nr = DACCESS;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_nr;
         IFETCH:  if (bus.pmem_resp) w_next = (bus.dread || bus.dwrite) ? DACCESS : COMMIT;
         DACCESS: if (bus.pmem_resp) w_next = COMMIT;
         COMMIT:  w_next = w_nr;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the strobes stay glitch-free and
   // hold steady for the whole wait; a write wins when dread and dwrite collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_inst         <= DATA_W'(NOP_INST);
         r_memRdata     <= '0;
         r_loadPipeline <= 1'b0;
         r_pmemRead     <= 1'b0;
         r_pmemWrite    <= 1'b0;
         r_pmemAddress  <= '0;
         r_pmemWdata    <= '0;
         r_pmemBe       <= '0;
      end else begin
         r_state        <= w_next;
         r_loadPipeline <= (w_next == COMMIT);
         r_pmemRead     <= (w_next == IFETCH) ||
                           ((w_next == DACCESS) && bus.dread && !bus.dwrite);
         r_pmemWrite    <= (w_next == DACCESS) && bus.dwrite;
         if (w_next == IFETCH) begin
            r_pmemAddress <= {bus.inst_addr[ADDR_W-1:2], 2'b00};
         end else if (w_next == DACCESS) begin
            r_pmemAddress <= {bus.mem_address[ADDR_W-1:2], 2'b00};
         end else begin
            r_pmemAddress <= '0;
         end
         if ((w_next == DACCESS) && bus.dwrite) begin
            r_pmemWdata <= bus.mem_wdata;
            r_pmemBe    <= bus.mem_byte_enable;
         end else begin
            r_pmemWdata <= '0;
            r_pmemBe    <= '0;
         end
         if ((r_state == IFETCH) && bus.pmem_resp) begin
            r_inst <= bus.pmem_rdata;
         end
         if ((r_state == DACCESS) && bus.pmem_resp && bus.dread && !bus.dwrite) begin
            r_memRdata <= bus.pmem_rdata;
         end
      end
   end

   assign w_wdCountEn = (r_state == IFETCH) || (r_state == DACCESS);
   assign w_wdClear   = (w_next != r_state);

   resp_watchdog #(
      .WDOG_CYCLES(WDOG_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_wdClear),
      .i_countEn (w_wdCountEn),
      .o_err     (err)
   );

   assign bus.inst             = r_inst;
   assign bus.mem_rdata        = r_memRdata;
   assign bus.load_pipeline    = r_loadPipeline;
   assign bus.pmem_read        = r_pmemRead;
   assign bus.pmem_write       = r_pmemWrite;
   assign bus.pmem_address     = r_pmemAddress;
   assign bus.pmem_wdata       = r_pmemWdata;
   assign bus.pmem_byte_enable = r_pmemBe;

   // Simultaneous read and write requests are a datapath bug.
   assert property (@(posedge clk) disable iff (!rst_n) !(bus.dread && bus.dwrite));

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Directed testbench for pipeline_mem_responder: a table of pipeline steps plus
// hand sequences for reset mid-fetch, the watchdog and fetch reuse (INST_REUSE_EN).
module tb_pipeline_mem_responder;
   import mem_resp_types::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int WDOG   = 64;

   typedef struct {
      logic        iread;
      logic [31:0] iaddr;
      logic        dread;
      logic        dwrite;
      logic [31:0] maddr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          lat;
      logic [31:0] frdata;
      logic [31:0] drdata;
      int          expCycles;
      int          expN;
      logic [1:0]  expKind0;
      logic [31:0] expAddr0;
      logic [1:0]  expKind1;
      logic [31:0] expAddr1;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic [31:0] expInst;
      logic [31:0] expMemRdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic err;

   int checkCount = 0;
   int failCount  = 0;

   int          obsCycles;
   int          obsN;
   logic [1:0]  accKind [2];
   logic [31:0] accAddr [2];
   logic [3:0]  obsBe;
   logic [31:0] obsWdata;
   logic        obsBadStrobe;

   vec_t vecs [7];

   always #5 clk = ~clk;

   pipeline_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   pipeline_mem_responder #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .err   (err)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one step's datapath inputs and plays the pmem side until load_pipeline.
   task automatic applyStimulus(input logic iread, input logic [31:0] iaddr,
                                input logic dread, input logic dwrite,
                                input logic [31:0] maddr, input logic [31:0] wdata,
                                input logic [3:0] be, input int lat,
                                input logic [31:0] frdata, input logic [31:0] drdata);
      int          waitCnt;
      int          c;
      bit          respPending;
      bit          inAccess;
      bit          done;
      logic [31:0] alignedI;
      bus.iread           = iread;
      bus.inst_addr       = iaddr;
      bus.dread           = dread;
      bus.dwrite          = dwrite;
      bus.mem_address     = maddr;
      bus.mem_wdata       = wdata;
      bus.mem_byte_enable = be;
      alignedI     = {iaddr[31:2], 2'b00};
      obsCycles    = 0;
      obsN         = 0;
      accKind[0]   = 2'd0;
      accKind[1]   = 2'd0;
      accAddr[0]   = 32'h0;
      accAddr[1]   = 32'h0;
      obsBe        = 4'h0;
      obsWdata     = 32'h0;
      obsBadStrobe = 1'b0;
      waitCnt      = 0;
      respPending  = 0;
      inAccess     = 0;
      done         = 0;
      c            = 0;
      while (!done && c < 400) begin
         @(posedge clk);
         #1;
         c++;
         obsCycles++;
         if (respPending) begin
            bus.pmem_resp = 1'b0;
            respPending   = 0;
            inAccess      = 0;
            waitCnt       = 0;
         end
         if (bus.load_pipeline) begin
            done = 1;
         end else if (bus.pmem_read || bus.pmem_write) begin
            if (bus.pmem_read && bus.pmem_write) obsBadStrobe = 1'b1;
            if (bus.pmem_read && bus.pmem_byte_enable != 4'h0) obsBadStrobe = 1'b1;
            if (!inAccess) begin
               inAccess = 1;
               if (obsN < 2) begin
                  accKind[obsN] = bus.pmem_write ? 2'd2 : 2'd1;
                  accAddr[obsN] = bus.pmem_address;
               end
               if (bus.pmem_write) begin
                  obsBe    = bus.pmem_byte_enable;
                  obsWdata = bus.pmem_wdata;
               end
               obsN++;
            end
            if (waitCnt == lat) begin
               bus.pmem_resp  = 1'b1;
               bus.pmem_rdata = (bus.pmem_address == alignedI && obsN == 1) ? frdata : drdata;
               respPending    = 1;
            end else begin
               waitCnt++;
            end
         end
      end
      bus.pmem_resp = 1'b0;
      if (!done) begin
         checkCount++;
         failCount++;
         $display("[TB] FAIL step timeout: got no load_pipeline, expected one within 400 cycles");
      end
   endtask

   task automatic checkStep(input string tag, input int expCycles, input int expN,
                            input logic [1:0] k0, input logic [31:0] a0,
                            input logic [1:0] k1, input logic [31:0] a1,
                            input logic [3:0] eBe, input logic [31:0] eWdata,
                            input logic [31:0] eInst, input logic [31:0] eMemRdata);
      checkOutput({tag, " cycles"}, 32'(obsCycles), 32'(expCycles));
      checkOutput({tag, " accesses"}, 32'(obsN), 32'(expN));
      if (expN >= 1) begin
         checkOutput({tag, " kind0"}, 32'(accKind[0]), 32'(k0));
         checkOutput({tag, " addr0"}, accAddr[0], a0);
      end
      if (expN >= 2) begin
         checkOutput({tag, " kind1"}, 32'(accKind[1]), 32'(k1));
         checkOutput({tag, " addr1"}, accAddr[1], a1);
      end
      if (k0 == 2'd2 || k1 == 2'd2) begin
         checkOutput({tag, " byte_enable"}, 32'(obsBe), 32'(eBe));
         checkOutput({tag, " wdata"}, obsWdata, eWdata);
      end
      checkOutput({tag, " strobe_rules"}, 32'(obsBadStrobe), 32'h0);
      checkOutput({tag, " inst"}, bus.inst, eInst);
      checkOutput({tag, " mem_rdata"}, bus.mem_rdata, eMemRdata);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3, 32'h00A00093, 32'h0,
                  5, 1, 2'd1, 32'h60, 2'd0, 32'h0, 4'h0, 32'h0, 32'h00A00093, 32'h0};
      vecs[1] = '{1'b1, 32'h64, 1'b1, 1'b0, 32'h106, 32'h0, 4'h0, 1, 32'h00410113, 32'hDEADBEEF,
                  5, 2, 2'd1, 32'h64, 2'd1, 32'h104, 4'h0, 32'h0, 32'h00410113, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h68, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h12345678, 32'h0,
                  2, 1, 2'd1, 32'h68, 2'd0, 32'h0, 4'h0, 32'h0, 32'h12345678, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 32'h6C, 1'b0, 1'b1, 32'h20B, 32'hAA, 4'b0100, 2, 32'h0000A023, 32'hBAD0BAD0,
                  7, 2, 2'd1, 32'h6C, 2'd2, 32'h208, 4'b0100, 32'hAA, 32'h0000A023, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 32'h70, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 32'h0,
                  1, 0, 2'd0, 32'h0, 2'd0, 32'h0, 4'h0, 32'h0, 32'h0000A023, 32'hDEADBEEF};
      vecs[5] = '{1'b0, 32'h70, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1, 32'h0, 32'hCAFEF00D,
                  3, 1, 2'd1, 32'h300, 2'd0, 32'h0, 4'h0, 32'h0, 32'h0000A023, 32'hCAFEF00D};
      vecs[6] = '{1'b1, 32'h70, 1'b1, 1'b0, 32'h3FF, 32'h0, 4'h0, 4, 32'h00000513, 32'h01020304,
                  11, 2, 2'd1, 32'h70, 2'd1, 32'h3FC, 4'h0, 32'h0, 32'h00000513, 32'h01020304};

      rst_n               = 1'b0;
      bus.iread           = 1'b1;
      bus.inst_addr       = 32'h40;
      bus.dread           = 1'b0;
      bus.dwrite          = 1'b0;
      bus.mem_address     = 32'h0;
      bus.mem_wdata       = 32'h0;
      bus.mem_byte_enable = 4'h0;
      bus.pmem_rdata      = 32'h0;
      bus.pmem_resp       = 1'b0;
      $display("[TB] reset and mid-fetch reset");

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset inst", bus.inst, 32'h00000013);
      checkOutput("reset mem_rdata", bus.mem_rdata, 32'h0);
      checkOutput("reset load_pipeline", 32'(bus.load_pipeline), 32'h0);
      checkOutput("reset pmem_read", 32'(bus.pmem_read), 32'h0);
      checkOutput("reset pmem_write", 32'(bus.pmem_write), 32'h0);
      checkOutput("reset err", 32'(err), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("first fetch pmem_read", 32'(bus.pmem_read), 32'h1);
      checkOutput("first fetch address", bus.pmem_address, 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midfetch reset pmem_read", 32'(bus.pmem_read), 32'h0);
      checkOutput("midfetch reset inst", bus.inst, 32'h00000013);
      checkOutput("midfetch reset load_pipeline", 32'(bus.load_pipeline), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("held reset pmem_read", 32'(bus.pmem_read), 32'h0);
      rst_n = 1'b1;

      $display("[TB] table-driven steps");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].iread, vecs[i].iaddr, vecs[i].dread, vecs[i].dwrite,
                       vecs[i].maddr, vecs[i].wdata, vecs[i].be, vecs[i].lat,
                       vecs[i].frdata, vecs[i].drdata);
         checkStep($sformatf("v%0d", i), vecs[i].expCycles, vecs[i].expN,
                   vecs[i].expKind0, vecs[i].expAddr0, vecs[i].expKind1, vecs[i].expAddr1,
                   vecs[i].expBe, vecs[i].expWdata, vecs[i].expInst, vecs[i].expMemRdata);
      end

      $display("[TB] watchdog");
      bus.iread  = 1'b1;
      bus.inst_addr = 32'h80;
      bus.dread  = 1'b0;
      bus.dwrite = 1'b0;
      for (int s = 0; s <= WDOG + 2; s++) begin
         @(posedge clk);
         #1;
         if (s == WDOG - 1) checkOutput("wdog err before limit", 32'(err), 32'h0);
         if (s == WDOG) checkOutput("wdog err at limit", 32'(err), 32'h1);
      end
      checkOutput("wdog still waiting", 32'(bus.pmem_read), 32'h1);
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = 32'h0DDF00D1;
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      checkOutput("wdog late resp load", 32'(bus.load_pipeline), 32'h1);
      checkOutput("wdog late resp inst", bus.inst, 32'h0DDF00D1);
      checkOutput("wdog err sticky", 32'(err), 32'h1);
      applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h00C00193, 32'h0);
      checkStep("after wdog", 3, 1, 2'd1, 32'h84, 2'd0, 32'h0, 4'h0, 32'h0,
                32'h00C00193, 32'h01020304);
      checkOutput("err still sticky", 32'(err), 32'h1);

      $display("[TB] stalled PC");
      applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h22222222, 32'h0);
`ifdef INST_REUSE_EN
      checkStep("stall reuse", 1, 0, 2'd0, 32'h0, 2'd0, 32'h0, 4'h0, 32'h0,
                32'h00C00193, 32'h01020304);
`else
      checkStep("stall refetch", 3, 1, 2'd1, 32'h84, 2'd0, 32'h0, 4'h0, 32'h0,
                32'h22222222, 32'h01020304);
`endif
      applyStimulus(1'b1, 32'h84, 1'b0, 1'b1, 32'h86, 32'h55, 4'b0001, 1, 32'h22222222, 32'h0);
`ifdef INST_REUSE_EN
      checkStep("stall store", 3, 1, 2'd2, 32'h84, 2'd0, 32'h0, 4'b0001, 32'h55,
                32'h00C00193, 32'h01020304);
`else
      checkStep("stall store", 5, 2, 2'd1, 32'h84, 2'd2, 32'h84, 4'b0001, 32'h55,
                32'h22222222, 32'h01020304);
`endif
      applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h33333333, 32'h0);
      checkStep("refetch after store", 3, 1, 2'd1, 32'h84, 2'd0, 32'h0, 4'h0, 32'h0,
                32'h33333333, 32'h01020304);

      $display("[TB] final reset");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("final reset err", 32'(err), 32'h0);
      checkOutput("final reset inst", bus.inst, 32'h00000013);
      checkOutput("final reset mem_rdata", bus.mem_rdata, 32'h0);
      checkOutput("final reset load_pipeline", 32'(bus.load_pipeline), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
